// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_pkg
// Purpose  : Default scan timing, LCD grid dimensions and index-width helper
//            shared by the LCD scan generator, its interface and sub-blocks.
// Revision : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    localparam int DEF_WIDTH      = 360;
    localparam int DEF_HEIGHT     = 360;
    localparam int DEF_H_TOTAL    = 444;
    localparam int DEF_V_TOTAL    = 492;
    localparam int DEF_HSYNC_POS  = 365;
    localparam int DEF_VSYNC_POS  = 365;
    localparam int DEF_LCD_COLS   = 32;
    localparam int DEF_LCD_ROWS   = 16;
    localparam int DEF_PIXEL_SIZE = 11;
    localparam int DEF_X_OFFSET   = 4;
    localparam int DEF_Y_OFFSET   = 92;

    // Width of an index into n entries; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage : lcd_pkg
`default_nettype wire

// File: rtl/lcd_scan_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : lcd_scan_gen_if
// Purpose  : Pixel-advance enable and scan outputs of the LCD scan generator.
//            master = generator side, slave = consumer side.
// Revision : 1.0 - initial release
// ============================================================================
interface lcd_scan_gen_if
    import lcd_pkg::*;
#(
    parameter int LCD_COLS = DEF_LCD_COLS,
    parameter int LCD_ROWS = DEF_LCD_ROWS
);
    localparam int c_col_w  = idx_w(LCD_COLS);
    localparam int c_row_w  = idx_w(LCD_ROWS);
    localparam int c_addr_w = idx_w(LCD_COLS * LCD_ROWS);

    logic                ce;
    logic [9:0]          x;
    logic [9:0]          y;
    logic                de;
    logic                hsync;
    logic                vsync;
    logic                frame_start;
    logic                in_lcd;
    logic [c_col_w-1:0]  lcd_x;
    logic [c_row_w-1:0]  lcd_y;
    logic [4:0]          sub_x;
    logic [4:0]          sub_y;
    logic [c_addr_w-1:0] video_addr;
    logic                grid_line;

    modport master (
        input  ce,
        output x, y, de, hsync, vsync, frame_start, in_lcd,
               lcd_x, lcd_y, sub_x, sub_y, video_addr, grid_line
    );

    modport slave (
        output ce,
        input  x, y, de, hsync, vsync, frame_start, in_lcd,
               lcd_x, lcd_y, sub_x, sub_y, video_addr, grid_line
    );

endinterface : lcd_scan_gen_if
`default_nettype wire

// File: rtl/lcd_axis_counter.sv
`default_nettype none
// ============================================================================
// Module   : lcd_axis_counter
// Purpose  : One scan axis, tracked one position ahead of the visible output.
//            Keeps position, window flag, sub-cell offset, cell index and the
//            cell's address contribution (cell * STRIDE), all incrementally.
//            o_ld_* expose the values being loaded this cycle so the parent
//            can register an address that matches the new lookahead state.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_axis_counter
    import lcd_pkg::*;
#(
    parameter int TOTAL      = DEF_H_TOTAL,
    parameter int OFFSET     = DEF_X_OFFSET,
    parameter int CELLS      = DEF_LCD_COLS,
    parameter int PIXEL_SIZE = DEF_PIXEL_SIZE,
    parameter int STRIDE     = 1,
    parameter int RESET_POS  = 1,
    parameter int CELL_W     = 5,
    parameter int BASE_W     = 9
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              i_step,
    output logic [9:0]             o_pos,
    output logic                   o_in,
    output logic [CELL_W-1:0]      o_cell,
    output logic [4:0]             o_sub,
    output logic                   o_ld_in,
    output logic [BASE_W-1:0]      o_ld_base
);

    localparam int c_end       = OFFSET + CELLS * PIXEL_SIZE;
    localparam bit c_rst_in    = (RESET_POS >= OFFSET) && (RESET_POS < c_end);
    localparam int c_rst_sub   = c_rst_in ? (RESET_POS - OFFSET) % PIXEL_SIZE : 0;
    localparam int c_rst_cell  = c_rst_in ? (RESET_POS - OFFSET) / PIXEL_SIZE : 0;

    localparam logic [9:0]        c_last     = 10'(TOTAL - 1);
    localparam logic [9:0]        c_off      = 10'(OFFSET);
    localparam logic [9:0]        c_end_pos  = 10'(c_end);
    localparam logic [4:0]        c_sub_last = 5'(PIXEL_SIZE - 1);
    localparam logic [BASE_W-1:0] c_stride   = BASE_W'(STRIDE);
    localparam logic [BASE_W-1:0] c_rst_base = BASE_W'(c_rst_cell * STRIDE);

    logic [BASE_W-1:0] r_base;

    logic [9:0]        w_nxt_pos;
    logic              w_nxt_in;
    logic [CELL_W-1:0] w_nxt_cell;
    logic [4:0]        w_nxt_sub;
    logic [BASE_W-1:0] w_nxt_base;

    // Next position along the axis: enter, leave or step inside the window.
    always_comb begin
        w_nxt_pos  = (o_pos == c_last) ? '0 : o_pos + 1'b1;
        w_nxt_in   = o_in;
        w_nxt_cell = o_cell;
        w_nxt_sub  = o_sub;
        w_nxt_base = r_base;
        if (w_nxt_pos == c_off) begin
            w_nxt_in   = 1'b1;
            w_nxt_cell = '0;
            w_nxt_sub  = '0;
            w_nxt_base = '0;
        end else if (o_in) begin
            // A wrap to 0 also closes a window that ends on the last position.
            if ((w_nxt_pos == c_end_pos) || (w_nxt_pos == '0)) begin
                w_nxt_in   = 1'b0;
                w_nxt_cell = '0;
                w_nxt_sub  = '0;
                w_nxt_base = '0;
            end else if (o_sub == c_sub_last) begin
                w_nxt_sub  = '0;
                w_nxt_cell = o_cell + 1'b1;
                w_nxt_base = r_base + c_stride;
            end else begin
                w_nxt_sub  = o_sub + 1'b1;
            end
        end
    end

    // Values loaded into the lookahead registers this cycle.
    always_comb begin
        o_ld_in   = reset ? c_rst_in   : (i_step ? w_nxt_in   : o_in);
        o_ld_base = reset ? c_rst_base : (i_step ? w_nxt_base : r_base);
    end

    // Lookahead axis state.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_pos  <= 10'(RESET_POS);
            o_in   <= c_rst_in;
            o_cell <= CELL_W'(c_rst_cell);
            o_sub  <= 5'(c_rst_sub);
            r_base <= c_rst_base;
        end else if (i_step) begin
            o_pos  <= w_nxt_pos;
            o_in   <= w_nxt_in;
            o_cell <= w_nxt_cell;
            o_sub  <= w_nxt_sub;
            r_base <= w_nxt_base;
        end
    end

endmodule : lcd_axis_counter
`default_nettype wire

// File: rtl/lcd_scan_gen.sv
`default_nettype none
// ============================================================================
// Module   : lcd_scan_gen
// Purpose  : Raster scan generator with an embedded LCD cell window. Two axis
//            counters run one pixel ahead; each ce cycle their state becomes
//            the visible output while video_addr names the next cell to fetch.
//            Build option: LCD_GRID_EN enables the grid_line cell-border flag.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_scan_gen
    import lcd_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int HEIGHT     = DEF_HEIGHT,
    parameter int H_TOTAL    = DEF_H_TOTAL,
    parameter int V_TOTAL    = DEF_V_TOTAL,
    parameter int HSYNC_POS  = DEF_HSYNC_POS,
    parameter int VSYNC_POS  = DEF_VSYNC_POS,
    parameter int LCD_COLS   = DEF_LCD_COLS,
    parameter int LCD_ROWS   = DEF_LCD_ROWS,
    parameter int PIXEL_SIZE = DEF_PIXEL_SIZE,
    parameter int X_OFFSET   = DEF_X_OFFSET,
    parameter int Y_OFFSET   = DEF_Y_OFFSET
) (
    input  wire logic       clk,
    input  wire logic       reset,
    lcd_scan_gen_if.master  bus
);

    localparam int c_col_w  = idx_w(LCD_COLS);
    localparam int c_row_w  = idx_w(LCD_ROWS);
    localparam int c_addr_w = idx_w(LCD_COLS * LCD_ROWS);

    localparam logic [9:0]  c_h_last = 10'(H_TOTAL - 1);
    localparam logic [9:0]  c_hs     = 10'(HSYNC_POS);
    localparam logic [9:0]  c_vs     = 10'(VSYNC_POS);
    localparam logic [10:0] c_width  = 11'(WIDTH);
    localparam logic [10:0] c_height = 11'(HEIGHT);

    if (X_OFFSET + LCD_COLS * PIXEL_SIZE > WIDTH) begin : g_chk_win_x
        $error("lcd_scan_gen: LCD window exceeds WIDTH");
    end
    if (Y_OFFSET + LCD_ROWS * PIXEL_SIZE > HEIGHT) begin : g_chk_win_y
        $error("lcd_scan_gen: LCD window exceeds HEIGHT");
    end
    if ((PIXEL_SIZE < 1) || (PIXEL_SIZE > 31)) begin : g_chk_pix
        $error("lcd_scan_gen: PIXEL_SIZE must be 1..31");
    end
    if (HSYNC_POS >= H_TOTAL) begin : g_chk_hs
        $error("lcd_scan_gen: HSYNC_POS must be below H_TOTAL");
    end
    if (VSYNC_POS >= V_TOTAL) begin : g_chk_vs
        $error("lcd_scan_gen: VSYNC_POS must be below V_TOTAL");
    end

    logic [9:0]          w_ax_pos, w_ay_pos;
    logic                w_ax_in, w_ay_in;
    logic [c_col_w-1:0]  w_ax_cell;
    logic [c_row_w-1:0]  w_ay_cell;
    logic [4:0]          w_ax_sub, w_ay_sub;
    logic                w_ax_ld_in, w_ay_ld_in;
    logic [c_addr_w-1:0] w_ax_ld_base, w_ay_ld_base;
    logic                w_x_wrap;

    assign w_x_wrap = (w_ax_pos == c_h_last);

    lcd_axis_counter #(
        .TOTAL(H_TOTAL), .OFFSET(X_OFFSET), .CELLS(LCD_COLS),
        .PIXEL_SIZE(PIXEL_SIZE), .STRIDE(1), .RESET_POS(1),
        .CELL_W(c_col_w), .BASE_W(c_addr_w)
    ) u_x_axis (
        .clk(clk), .reset(reset), .i_step(bus.ce),
        .o_pos(w_ax_pos), .o_in(w_ax_in), .o_cell(w_ax_cell), .o_sub(w_ax_sub),
        .o_ld_in(w_ax_ld_in), .o_ld_base(w_ax_ld_base)
    );

    lcd_axis_counter #(
        .TOTAL(V_TOTAL), .OFFSET(Y_OFFSET), .CELLS(LCD_ROWS),
        .PIXEL_SIZE(PIXEL_SIZE), .STRIDE(LCD_COLS), .RESET_POS(0),
        .CELL_W(c_row_w), .BASE_W(c_addr_w)
    ) u_y_axis (
        .clk(clk), .reset(reset), .i_step(bus.ce && w_x_wrap),
        .o_pos(w_ay_pos), .o_in(w_ay_in), .o_cell(w_ay_cell), .o_sub(w_ay_sub),
        .o_ld_in(w_ay_ld_in), .o_ld_base(w_ay_ld_base)
    );

    // Visible outputs take the lookahead state on each ce; pulses last one clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.x           <= '0;
            bus.y           <= '0;
            bus.de          <= 1'b1;
            bus.hsync       <= 1'b0;
            bus.vsync       <= 1'b0;
            bus.frame_start <= 1'b0;
            bus.in_lcd      <= 1'b0;
            bus.lcd_x       <= '0;
            bus.lcd_y       <= '0;
            bus.sub_x       <= '0;
            bus.sub_y       <= '0;
        end else if (bus.ce) begin
            bus.x           <= w_ax_pos;
            bus.y           <= w_ay_pos;
            bus.de          <= ({1'b0, w_ax_pos} < c_width) && ({1'b0, w_ay_pos} < c_height);
            bus.hsync       <= (w_ax_pos == c_hs);
            bus.vsync       <= (w_ax_pos == c_hs) && (w_ay_pos == c_vs);
            bus.frame_start <= (w_ax_pos == '0) && (w_ay_pos == '0);
            bus.in_lcd      <= w_ax_in && w_ay_in;
            bus.lcd_x       <= w_ax_cell;
            bus.lcd_y       <= w_ay_cell;
            bus.sub_x       <= w_ax_sub;
            bus.sub_y       <= w_ay_sub;
        end else begin
            bus.hsync       <= 1'b0;
            bus.vsync       <= 1'b0;
            bus.frame_start <= 1'b0;
        end
    end

    // Address of the new lookahead position; reset is folded into the ld values.
    always_ff @(posedge clk) begin
        bus.video_addr <= (w_ax_ld_in && w_ay_ld_in) ? (w_ay_ld_base + w_ax_ld_base) : '0;
    end

`ifdef LCD_GRID_EN
    localparam logic [4:0] c_sub_last = 5'(PIXEL_SIZE - 1);

    // Cell border flag for the position being made visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.grid_line <= 1'b0;
        end else if (bus.ce) begin
            bus.grid_line <= w_ax_in && w_ay_in &&
                             ((w_ax_sub == c_sub_last) || (w_ay_sub == c_sub_last));
        end
    end
`else
    assign bus.grid_line = 1'b0;
`endif

endmodule : lcd_scan_gen
`default_nettype wire

// File: tb/tb_lcd_scan_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_scan_gen
// Purpose  : Directed self-checking bench for lcd_scan_gen. Three instances
//            share clock, reset and ce: A uses default timing, B keeps the
//            default LCD window geometry on a shorter raster so the last cell
//            is reachable quickly, S is a tiny raster for whole-frame counts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_scan_gen;
    import lcd_pkg::*;

`ifdef LCD_GRID_EN
    localparam logic c_grid = 1'b1;
`else
    localparam logic c_grid = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic ce    = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int k        = 0;   // ce=1 cycles since reset release

    always #5 clk = ~clk;

    lcd_scan_gen_if #(.LCD_COLS(32), .LCD_ROWS(16)) bus_a ();
    lcd_scan_gen_if #(.LCD_COLS(32), .LCD_ROWS(16)) bus_b ();
    lcd_scan_gen_if #(.LCD_COLS(4),  .LCD_ROWS(2))  bus_s ();

    assign bus_a.ce = ce;
    assign bus_b.ce = ce;
    assign bus_s.ce = ce;

    lcd_scan_gen u_a (.clk(clk), .reset(reset), .bus(bus_a));

    lcd_scan_gen #(
        .WIDTH(360), .HEIGHT(180), .H_TOTAL(360), .V_TOTAL(200),
        .HSYNC_POS(358), .VSYNC_POS(190), .Y_OFFSET(0)
    ) u_b (.clk(clk), .reset(reset), .bus(bus_b));

    lcd_scan_gen #(
        .WIDTH(16), .HEIGHT(10), .H_TOTAL(20), .V_TOTAL(12),
        .HSYNC_POS(17), .VSYNC_POS(11), .LCD_COLS(4), .LCD_ROWS(2),
        .PIXEL_SIZE(3), .X_OFFSET(2), .Y_OFFSET(3)
    ) u_s (.clk(clk), .reset(reset), .bus(bus_s));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic adv(input int n);
        ce = 1'b1;
        repeat (n) tick();
        k += n;
    endtask

    task automatic goto_k(input int target);
        adv(target - k);
    endtask

    task automatic check_pos_a(input string tag);
        check({tag, "_ax"}, 32'(bus_a.x), 32'(k % 444));
        check({tag, "_ay"}, 32'(bus_a.y), 32'((k / 444) % 492));
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_x"},     32'(bus_a.x), 0);
        check({tag, "_y"},     32'(bus_a.y), 0);
        check({tag, "_de"},    32'(bus_a.de), 1);
        check({tag, "_hs"},    32'(bus_a.hsync), 0);
        check({tag, "_vs"},    32'(bus_a.vsync), 0);
        check({tag, "_fs"},    32'(bus_a.frame_start), 0);
        check({tag, "_inl"},   32'(bus_a.in_lcd), 0);
        check({tag, "_lcdx"},  32'(bus_a.lcd_x), 0);
        check({tag, "_lcdy"},  32'(bus_a.lcd_y), 0);
        check({tag, "_subx"},  32'(bus_a.sub_x), 0);
        check({tag, "_suby"},  32'(bus_a.sub_y), 0);
        check({tag, "_addr"},  32'(bus_a.video_addr), 0);
        check({tag, "_grid"},  32'(bus_a.grid_line), 0);
    endtask

    initial begin
        int n_hs, n_vs, n_fs, n_in, n_de;
        logic fs_origin;

        // Reset with ce high: reset must win.
        reset = 1'b1;
        ce    = 1'b1;
        tick();
        tick();
        check_reset_a("rst");
        reset = 1'b0;

        // One full frame of the small raster, counting its pulses.
        n_hs = 0; n_vs = 0; n_fs = 0; n_in = 0; n_de = 0;
        fs_origin = 1'b0;
        for (int i = 1; i <= 240; i++) begin
            tick();
            k++;
            if (i == 1) check("first_x", 32'(bus_a.x), 1);
            n_hs += int'(bus_s.hsync);
            n_vs += int'(bus_s.vsync);
            n_fs += int'(bus_s.frame_start);
            n_in += int'(bus_s.in_lcd);
            n_de += int'(bus_s.de);
            if (bus_s.frame_start && bus_s.x == 10'd0 && bus_s.y == 10'd0) fs_origin = 1'b1;
        end
        check("s_hsync_cnt", 32'(n_hs), 12);
        check("s_vsync_cnt", 32'(n_vs), 1);
        check("s_fs_cnt",    32'(n_fs), 1);
        check("s_fs_origin", 32'(fs_origin), 1);
        check("s_inlcd_cnt", 32'(n_in), 72);
        check("s_de_cnt",    32'(n_de), 160);
        check_pos_a("k240");

        // Horizontal window edges on the first window line.
        goto_k(92 * 444 + 3);
        check_pos_a("p3_92");
        check("p3_92_inl",  32'(bus_a.in_lcd), 0);
        check("p3_92_subx", 32'(bus_a.sub_x), 0);
        check("p3_92_addr", 32'(bus_a.video_addr), 0);
        adv(1);
        check("p4_92_inl",  32'(bus_a.in_lcd), 1);
        check("p4_92_lcdx", 32'(bus_a.lcd_x), 0);
        check("p4_92_lcdy", 32'(bus_a.lcd_y), 0);
        check("p4_92_subx", 32'(bus_a.sub_x), 0);
        check("p4_92_suby", 32'(bus_a.sub_y), 0);
        check("p4_92_grid", 32'(bus_a.grid_line), 0);
        goto_k(92 * 444 + 14);
        check("p14_92_subx", 32'(bus_a.sub_x), 10);
        check("p14_92_addr", 32'(bus_a.video_addr), 1);
        adv(1);
        check("p15_92_lcdx", 32'(bus_a.lcd_x), 1);
        check("p15_92_subx", 32'(bus_a.sub_x), 0);
        goto_k(92 * 444 + 356);
        check("p356_92_inl", 32'(bus_a.in_lcd), 0);

        // Last window pixel of a line: lookahead is outside the window.
        goto_k(102 * 444 + 355);
        check_pos_a("p355_102");
        check("p355_102_inl",  32'(bus_a.in_lcd), 1);
        check("p355_102_lcdx", 32'(bus_a.lcd_x), 31);
        check("p355_102_subx", 32'(bus_a.sub_x), 10);
        check("p355_102_suby", 32'(bus_a.sub_y), 10);
        check("p355_102_addr", 32'(bus_a.video_addr), 0);
        check("p355_102_grid", 32'(bus_a.grid_line), 32'(c_grid));
        adv(1);
        check("p356_102_inl",  32'(bus_a.in_lcd), 0);
        check("p356_102_lcdx", 32'(bus_a.lcd_x), 0);
        check("p356_102_suby", 32'(bus_a.sub_y), 10);
        check("p356_102_grid", 32'(bus_a.grid_line), 0);

        // Next row fetch: lookahead (4,103) is cell row 1, column 0.
        goto_k(103 * 444 + 3);
        check("p3_103_addr", 32'(bus_a.video_addr), 32);
        check("p3_103_lcdy", 32'(bus_a.lcd_y), 1);
        check("p3_103_suby", 32'(bus_a.sub_y), 0);

        // ce toggled 1/0 around hsync: positions stretch, pulses stay one clock.
        goto_k(103 * 444 + 364);
        check_pos_a("p364_103");
        for (int j = 0; j < 6; j++) begin
            ce = 1'b1;
            tick();
            k++;
            check("tg_on_x",  32'(bus_a.x), 32'(k % 444));
            check("tg_on_hs", 32'(bus_a.hsync), 32'((k % 444) == 365));
            check("tg_on_vs", 32'(bus_a.vsync), 0);
            ce = 1'b0;
            tick();
            check("tg_off_x",  32'(bus_a.x), 32'(k % 444));
            check("tg_off_hs", 32'(bus_a.hsync), 0);
        end

        // Bottom-right LCD cell on instance B.
        goto_k(175 * 360 + 354);
        check("b354_175_x",    32'(bus_b.x), 354);
        check("b354_175_y",    32'(bus_b.y), 175);
        check("b354_175_addr", 32'(bus_b.video_addr), 511);
        adv(1);
        check("b355_175_inl",  32'(bus_b.in_lcd), 1);
        check("b355_175_lcdx", 32'(bus_b.lcd_x), 31);
        check("b355_175_lcdy", 32'(bus_b.lcd_y), 15);
        check("b355_175_subx", 32'(bus_b.sub_x), 10);
        check("b355_175_suby", 32'(bus_b.sub_y), 10);
        check("b355_175_addr", 32'(bus_b.video_addr), 0);
        check("b355_175_grid", 32'(bus_b.grid_line), 32'(c_grid));

        // Mid-frame reset on A at (200,150).
        goto_k(150 * 444 + 200);
        check_pos_a("p200_150");
        check("p200_150_inl",  32'(bus_a.in_lcd), 1);
        check("p200_150_lcdx", 32'(bus_a.lcd_x), 17);
        check("p200_150_subx", 32'(bus_a.sub_x), 9);
        check("p200_150_lcdy", 32'(bus_a.lcd_y), 5);
        check("p200_150_suby", 32'(bus_a.sub_y), 3);
        reset = 1'b1;
        ce    = 1'b1;
        tick();
        check_reset_a("mrst");
        reset = 1'b0;
        tick();
        check("mrst_next_x",  32'(bus_a.x), 1);
        check("mrst_next_y",  32'(bus_a.y), 0);
        check("mrst_next_hs", 32'(bus_a.hsync), 0);
        check("mrst_next_vs", 32'(bus_a.vsync), 0);
        check("mrst_next_fs", 32'(bus_a.frame_start), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_lcd_scan_gen
`default_nettype wire
